// File: rtl/multi_mode_timer.sv
// Countdown timer in whole seconds. A prescaler divides the system clock into seconds ticks.
// Modes: one-shot or periodic. Supports pause/resume and restart while running.
module multi_mode_timer #(
  parameter int CLK_DIV = 8,
  parameter int WIDTH   = 4,
  parameter int DIV_W   = $clog2(CLK_DIV)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             startTimer,
  input  logic [WIDTH-1:0] value,
  input  logic             mode,
  input  logic             pause,
  output logic             clock1Hz,
  output logic             expired,
  output logic             indicator,
  output logic [DIV_W-1:0] counter,
  output logic [WIDTH-1:0] counter1Hz
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             mode_latch;
  logic             tick;
  logic             active;

  assign tick   = (counter == LAST);
  assign active = (state == RUN) || (state == PAUSED);

  // NOTE: every register in this block uses <= so all state updates see the
  // pre-edge values; mixing in blocking writes would create order-dependent races.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      counter1Hz <= '0;
      reload     <= '0;
      mode_latch <= 1'b0;
      expired    <= 1'b0;
    end else if (startTimer) begin
      // A start request overrides any tick, pause or expiry in the same cycle.
      reload     <= value;
      mode_latch <= mode;
      counter    <= '0;
      counter1Hz <= value;
      if (value != '0) begin
        state   <= RUN;
        expired <= 1'b0;
      end else begin
        state   <= DONE;
        expired <= 1'b1;
      end
    end else begin
      case (state)
        RUN, PAUSED: begin
          if (pause) begin
            // Freeze counter and counter1Hz exactly as they stand.
            state   <= PAUSED;
            expired <= 1'b0;
          end else if (tick) begin
            counter <= '0;
            if (counter1Hz == ONE) begin
              if (mode_latch) begin
                counter1Hz <= reload;
                state      <= RUN;
                expired    <= 1'b1;
              end else begin
                counter1Hz <= '0;
                state      <= DONE;
                expired    <= 1'b1;
              end
            end else begin
              if (counter1Hz != '0) counter1Hz <= counter1Hz - ONE;
              state   <= RUN;
              expired <= 1'b0;
            end
          end else begin
            // The resume edge out of PAUSED counts as a normal running edge.
            counter <= counter + DIV_W'(1);
            state   <= RUN;
            expired <= 1'b0;
          end
        end
        default: begin
          // IDLE and DONE: prescaler parked, expired and counter1Hz held.
          counter <= '0;
        end
      endcase
    end
  end

  // Square wave and LED drive are decoded purely from registered state.
  assign clock1Hz = active && (counter < HALF);

  // NOTE: default assignment first so no path through the case leaves indicator
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    indicator = 1'b0;
    case (state)
      RUN:     indicator = clock1Hz;
      PAUSED:  indicator = 1'b1;
      DONE:    indicator = 1'b1;
      default: indicator = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multi_mode_timer.sv
// Directed bench for multi_mode_timer (CLK_DIV=4, WIDTH=4).
// Outputs are sampled 1ns after each rising edge. Edge numbers are relative to each start.
module tb_multi_mode_timer;

  localparam int CLK_DIV = 4;
  localparam int WIDTH   = 4;
  localparam int DIV_W   = 2;

  logic             clock;
  logic             reset;
  logic             startTimer;
  logic [WIDTH-1:0] value;
  logic             mode;
  logic             pause;
  logic             clock1Hz;
  logic             expired;
  logic             indicator;
  logic [DIV_W-1:0] counter;
  logic [WIDTH-1:0] counter1Hz;

  int checks = 0;
  int errors = 0;

  multi_mode_timer #(.CLK_DIV(CLK_DIV), .WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .startTimer (startTimer),
    .value      (value),
    .mode       (mode),
    .pause      (pause),
    .clock1Hz   (clock1Hz),
    .expired    (expired),
    .indicator  (indicator),
    .counter    (counter),
    .counter1Hz (counter1Hz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
  endtask

  task automatic expect_all(input string tag, input int ck, input int ex, input int ind,
                            input int cnt, input int sec);
    check({tag, ".clock1Hz"},   32'(clock1Hz),   32'(ck));
    check({tag, ".expired"},    32'(expired),    32'(ex));
    check({tag, ".indicator"},  32'(indicator),  32'(ind));
    check({tag, ".counter"},    32'(counter),    32'(cnt));
    check({tag, ".counter1Hz"}, 32'(counter1Hz), 32'(sec));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    startTimer = 1'b0;
    value      = '0;
    mode       = 1'b0;
    pause      = 1'b0;

    // Reset held 3 cycles, then 20 idle cycles: everything 0.
    repeat (3) step();
    expect_all("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      expect_all($sformatf("idle%0d", i), 0, 0, 0, 0, 0);
    end

    // One-shot, value 3: seconds 3/2/1/0 at edges 0/4/8/12.
    value = 4'd3; mode = 1'b0; startTimer = 1'b1;
    step();
    startTimer = 1'b0;
    expect_all("os_e0", 1, 0, 1, 0, 3);
    for (int e = 1; e < 12; e++) begin
      step();
      expect_all($sformatf("os_e%0d", e), int'((e % 4) < 2), 0, int'((e % 4) < 2),
                 e % 4, 3 - e / 4);
    end
    step();
    expect_all("os_e12", 0, 1, 1, 0, 0);
    for (int i = 0; i < 30; i++) begin
      step();
      expect_all($sformatf("os_hold%0d", i), 0, 1, 1, 0, 0);
    end

    // Pause while DONE is ignored.
    pause = 1'b1;
    repeat (3) step();
    expect_all("done_pause", 0, 1, 1, 0, 0);
    pause = 1'b0;

    // Reset clears the expiry, then a zero load expires immediately.
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_all("rst_clear", 0, 0, 0, 0, 0);
    value = 4'd0; mode = 1'b0; startTimer = 1'b1;
    step();
    startTimer = 1'b0;
    expect_all("zero_e0", 0, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      expect_all($sformatf("zero_hold%0d", i), 0, 1, 1, 0, 0);
    end

    // Periodic, value 2: expiry pulses at edges 8, 16, 24; seconds 2,1,2,1...
    value = 4'd2; mode = 1'b1; startTimer = 1'b1;
    step();
    startTimer = 1'b0;
    expect_all("per_e0", 1, 0, 1, 0, 2);
    for (int e = 1; e < 32; e++) begin
      step();
      expect_all($sformatf("per_e%0d", e), int'((e % 4) < 2), int'((e % 8) == 0),
                 int'((e % 4) < 2), e % 4, ((e % 8) < 4) ? 2 : 1);
    end

    // Restart lands on the edge-32 reload/expiry: the new load wins, no pulse.
    value = 4'd3; mode = 1'b0; startTimer = 1'b1;
    step();
    startTimer = 1'b0;
    expect_all("restart_e32", 1, 0, 1, 0, 3);
    step();
    expect_all("restart_e33", 1, 0, 1, 1, 3);

    // Reset together with a start: reset wins and the timer stays idle.
    reset = 1'b1; value = 4'd5; startTimer = 1'b1;
    step();
    reset = 1'b0; startTimer = 1'b0;
    expect_all("rst_start", 0, 0, 0, 0, 0);
    step();
    expect_all("rst_start_idle", 0, 0, 0, 0, 0);

    // Pause sampled high at edges 2..11: frozen at counter 1, expiry moves to edge 22.
    value = 4'd3; mode = 1'b0; startTimer = 1'b1;
    step();
    startTimer = 1'b0;
    expect_all("pz_e0", 1, 0, 1, 0, 3);
    step();
    expect_all("pz_e1", 1, 0, 1, 1, 3);
    pause = 1'b1;
    for (int e = 2; e < 12; e++) begin
      step();
      expect_all($sformatf("pz_e%0d", e), 1, 0, 1, 1, 3);
    end
    pause = 1'b0;
    for (int e = 12; e < 22; e++) begin
      step();
      expect_all($sformatf("pz_e%0d", e), int'(((e - 10) % 4) < 2), 0,
                 int'(((e - 10) % 4) < 2), (e - 10) % 4, 3 - (e - 10) / 4);
    end
    step();
    expect_all("pz_e22", 0, 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_mode_timer.md
Name: multi_mode_timer

Overview:
Parametrised second-based countdown timer for the anti-theft controller; successor to the fixed 4-bit Timer1Hz. Divides the system clock into a seconds tick, counts down a loaded value, and flags expiry. Adds configurable divider and count width, one-shot/periodic mode, pause/resume, and restart-while-running. Drives arming, alarm and door-delay timing in the FSM above it.

Parameters:
CLK_DIV, 8, system clock cycles per seconds tick (must be >= 2).
WIDTH, 4, width of loaded value and seconds counter.
DIV_W, $clog2(CLK_DIV), prescaler width (derived, not overridden).

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
startTimer  input  1  level-sampled load/start request
value  input  WIDTH  seconds to count; latched when startTimer is sampled high
mode  input  1  0 = one-shot, 1 = periodic; latched with value
pause  input  1  freeze countdown while high (RUN/PAUSED only)
clock1Hz  output  1  divided-clock square wave
expired  output  1  expiry flag (level in one-shot, 1-cycle pulse in periodic)
indicator  output  1  status LED drive
counter  output  DIV_W  prescaler count
counter1Hz  output  WIDTH  remaining seconds

Behaviour:
- One clock; reset synchronous, active-high; reset beats every other input.
- Reset: state IDLE; counter, counter1Hz, reload, mode latch = 0; clock1Hz, expired, indicator = 0.
- States: IDLE, RUN, PAUSED, DONE.
- startTimer high at edge k, any non-reset state: reload <= value, modeLatch <= mode, counter <= 0, counter1Hz <= value. If value != 0, state <= RUN, expired <= 0. If value == 0, state <= DONE, expired <= 1 at edge k.
- startTimer beats tick, pause and expiry in the same cycle.
- RUN, pause low: counter increments. At counter == CLK_DIV-1 (tick), counter wraps to 0 and counter1Hz decrements. First tick is at edge k+CLK_DIV.
- Tick with counter1Hz == 1, one-shot: counter1Hz <= 0, state <= DONE, expired <= 1. expired holds until the next start or reset.
- Tick with counter1Hz == 1, periodic: counter1Hz <= reload, stay in RUN, expired high for exactly one cycle.
- Expiry edges for value N: k + N*CLK_DIV (one-shot). Periodic repeats every N*CLK_DIV cycles.
- RUN with pause high at an edge: state <= PAUSED; counter and counter1Hz are frozen from that edge.
- PAUSED with pause low: state <= RUN; counting resumes from the frozen counter. Pause in IDLE or DONE is ignored.
- clock1Hz = 1 when state is RUN or PAUSED and counter < CLK_DIV/2; otherwise 0. It is frozen while PAUSED.
- indicator: IDLE 0; RUN follows clock1Hz; PAUSED 1; DONE 1.
- In IDLE and DONE, counter is held at 0.
- Arithmetic is unsigned. counter1Hz never decrements below 0; reload never exceeds 2^WIDTH-1.
- Outputs are registered or decoded directly from registered state. No combinational path from inputs to outputs.

Test Plan:
- Reset, idle (CLK_DIV=4, WIDTH=4): hold reset 3 cycles, then idle 20 cycles -> all outputs 0, counter1Hz 0, counter 0.
- One-shot expiry: value=3, mode=0, startTimer high for 1 cycle at edge 0 -> counter1Hz = 3 at edge 0, 2 at edge 4, 1 at edge 8, 0 at edge 12. expired and indicator rise at edge 12 and stay high 30 cycles; clock1Hz pattern 1,1,0,0 during RUN.
- Zero load: value=0, start -> expired = 1 and indicator = 1 after the next edge, counter1Hz = 0, no clock1Hz activity.
- Periodic: value=2, mode=1, start at edge 0 -> expired 1-cycle pulses at edges 8, 16, 24. counter1Hz goes 2,1,2,1,...; state stays RUN.
- Pause: value=3, one-shot, pause high from edge 2 to edge 12 -> counter and counter1Hz frozen; indicator 1 while paused. Expiry delayed by 10 cycles to edge 22.
- Restart/reset collisions: start asserted on the edge where periodic counter1Hz==1 ticks -> reload wins, no expired pulse. reset asserted mid-RUN together with startTimer -> all outputs 0 next cycle, state IDLE.
